// File: rtl/fft_bfly_addsub_16b.sv
// Radix-2 butterfly add/subtract stage: two-register pipeline producing A+B and A-B
// on 16-bit complex operands. Define BFLY_SAT_EN to saturate overflowing lanes when SCALE=0.

module ksa_top_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c0,
    output logic [15:0] s,
    output logic        o_carry
);
    logic [15:0] g0, p0, g1, p1, g2, p2, g3, g4;
    logic [15:8] p3;

    // Carry-in folded into bit 0 generate so prefix G[i] is the carry out of bit i.
    assign p0 = a ^ b;
    assign g0 = (a & b) | {15'b0, p0[0] & c0};

    for (genvar i = 0; i < 16; i++) begin : g_lv1
        if (i >= 1) begin : g_op
            assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
            assign p1[i] = p0[i] & p0[i-1];
        end else begin : g_cp
            assign g1[i] = g0[i];
            assign p1[i] = p0[i];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_lv2
        if (i >= 2) begin : g_op
            assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
            assign p2[i] = p1[i] & p1[i-2];
        end else begin : g_cp
            assign g2[i] = g1[i];
            assign p2[i] = p1[i];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_lv3
        if (i >= 4) begin : g_op
            assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
        end else begin : g_cp
            assign g3[i] = g2[i];
        end
        if (i >= 8) begin : g_pp
            assign p3[i] = p2[i] & p2[i-4];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_lv4
        if (i >= 8) begin : g_op
            assign g4[i] = g3[i] | (p3[i] & g3[i-8]);
        end else begin : g_cp
            assign g4[i] = g3[i];
        end
    end

    assign s       = p0 ^ {g4[14:0], c0};
    assign o_carry = g4[15];
endmodule

module fft_bfly_addsub_16b #(
    parameter int SCALE = 1,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a_re,
    input  logic [15:0]      in_a_im,
    input  logic [15:0]      in_b_re,
    input  logic [15:0]      in_b_im,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             clr_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum_re,
    output logic [15:0]      out_sum_im,
    output logic [15:0]      out_dif_re,
    output logic [15:0]      out_dif_im,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_ovf,
    output logic             ovf_sticky
);
    logic             s1_valid, s2_valid;
    logic [15:0]      s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic [IDX_W-1:0] s1_idx;
    logic             adv1, adv2;

    // Handshake: a beat moves on a port when valid && ready are both high at the
    // rising edge; ready never depends on the same port's valid, and a stalled
    // output holds its data until taken.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    logic [15:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;
    logic        sum_re_c, sum_im_c, dif_re_c, dif_im_c;

    ksa_top_16b u_sum_re (.a(s1_a_re), .b(s1_b_re),  .c0(1'b0), .s(sum_re_s), .o_carry(sum_re_c));
    ksa_top_16b u_sum_im (.a(s1_a_im), .b(s1_b_im),  .c0(1'b0), .s(sum_im_s), .o_carry(sum_im_c));
    ksa_top_16b u_dif_re (.a(s1_a_re), .b(~s1_b_re), .c0(1'b1), .s(dif_re_s), .o_carry(dif_re_c));
    ksa_top_16b u_dif_im (.a(s1_a_im), .b(~s1_b_im), .c0(1'b1), .s(dif_im_s), .o_carry(dif_im_c));

    // Returns {lane_ovf, result}; bop is the operand actually fed to the adder.
    function automatic logic [16:0] lane_post(input logic [15:0] a, input logic [15:0] bop,
                                              input logic [15:0] s, input logic co);
        logic        ovf;
        logic [15:0] res;
        if (SCALE != 0) begin
            res = {a[15] ^ bop[15] ^ co, s[15:1]};
            ovf = 1'b0;
        end else begin
            ovf = (a[15] == bop[15]) && (s[15] != a[15]);
            res = s;
`ifdef BFLY_SAT_EN
            if (ovf) res = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        end
        return {ovf, res};
    endfunction

    logic [16:0] l_sum_re, l_sum_im, l_dif_re, l_dif_im;

    assign l_sum_re = lane_post(s1_a_re, s1_b_re,  sum_re_s, sum_re_c);
    assign l_sum_im = lane_post(s1_a_im, s1_b_im,  sum_im_s, sum_im_c);
    assign l_dif_re = lane_post(s1_a_re, ~s1_b_re, dif_re_s, dif_re_c);
    assign l_dif_im = lane_post(s1_a_im, ~s1_b_im, dif_im_s, dif_im_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_b_re  <= '0;
            s1_b_im  <= '0;
            s1_idx   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a_re <= in_a_re;
                s1_a_im <= in_a_im;
                s1_b_re <= in_b_re;
                s1_b_im <= in_b_im;
                s1_idx  <= in_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_sum_re <= '0;
            out_sum_im <= '0;
            out_dif_re <= '0;
            out_dif_im <= '0;
            out_idx    <= '0;
            out_ovf    <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sum_re <= l_sum_re[15:0];
                out_sum_im <= l_sum_im[15:0];
                out_dif_re <= l_dif_re[15:0];
                out_dif_im <= l_dif_im[15:0];
                out_idx    <= s1_idx;
                out_ovf    <= l_sum_re[16] | l_sum_im[16] | l_dif_re[16] | l_dif_im[16];
            end
        end
    end

    // Clear wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end else if (s2_valid && out_ready && out_ovf) begin
            ovf_sticky <= 1'b1;
        end
    end
endmodule

// File: doc/fft_bfly_addsub_16b.md
Name:
fft_bfly_addsub_16b

Overview:
Pipelined radix-2 butterfly add/subtract stage for the 64-point FFT datapath. It sits directly downstream of the twiddle multiplier and consumes its 16-bit complex operands. Using four ksa_top_16b instances, it produces A+B and A-B for both real and imaginary parts. Each pass can optionally scale the result by 1/2, and a valid/ready handshake provides backpressure.

Parameters:
SCALE, 1, 1 = arithmetic shift right by 1 of the 17-bit true result (no growth, no overflow possible); 0 = keep the low 16 bits (overflow possible).
IDX_W, 6, width of the sample index/tag passed through alongside the data.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  stage can accept the operand pair.
in_a_re, in_a_im  in  16 each  operand A, signed two's complement.
in_b_re, in_b_im  in  16 each  operand B (already twiddled), signed.
in_idx  in  IDX_W  tag carried with the pair.
clr_ovf  in  1  synchronous clear of ovf_sticky.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_sum_re, out_sum_im  out  16 each  A+B, scaled per SCALE.
out_dif_re, out_dif_im  out  16 each  A-B, scaled per SCALE.
out_idx  out  IDX_W  tag that entered with this pair.
out_ovf  out  1  overflow occurred on any of the 4 lanes of this result (SCALE=0 only).
ovf_sticky  out  1  OR of all out_ovf values delivered since reset or the last clear.

Behaviour:
- Two register stages, S1 (operands plus tag) and S2 (results plus tag), each with its own valid bit.
- Latency is 2 cycles from input acceptance to out_valid when out_ready is held high. Throughput is 1 pair per cycle.
- Stage advance rules:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is combinational with no dependency on in_valid, so no comb loop exists toward the upstream stage.
- Transfers:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
  - While out_valid is high and out_ready is low, the out_* data must hold stable.
- Arithmetic, between S1 and S2:
  - Sum lane: ksa_top_16b with c0=0 and operands a, b.
  - Difference lane: ksa_top_16b with c0=1 and operands a, ~b.
  - The 17-bit true signed result has bit16 = a[15] ^ bop[15] ^ o_carry, where bop is b for the sum lane and ~b for the difference lane.
  - SCALE=1: result = {bit16, s[15:1]}. This is floor rounding (truncation toward -inf). lane_ovf = 0.
  - SCALE=0: result = s[15:0]. lane_ovf = (a[15]==bop[15]) && (s[15]!=a[15]).
- out_ovf is the OR of the four lane_ovf values, registered in S2 together with its data.
- ovf_sticky:
  - Set on each output transfer with out_ovf=1.
  - clr_ovf takes priority over a set in the same cycle.
- Reset (asynchronous, mid-operation included):
  - s1_valid, s2_valid, out_valid, out_ovf and ovf_sticky go to 0.
  - All data and tag registers go to 0.
  - Any in-flight pairs are discarded.
  - in_ready is 1 from the first clock edge after rst is released.
- Boundary cases:
  - Pipeline full with out_ready=0: in_ready=0, and both stages hold their contents.
  - out_ready rises: S2 drains, S1 moves to S2, and a new input is accepted in the same cycle.
  - in_valid=1 with in_ready=0: the pair is not taken, and upstream must hold it.
  - Extreme inputs: -32768 - (-32768) = 0 with no overflow. 32767 + 32767 overflows when SCALE=0.

Optional Feature:
- Macro: BFLY_SAT_EN.
- Defined: when SCALE=0, any lane with lane_ovf=1 saturates instead of wrapping. The clamp is to 0x7FFF if a[15]=0, otherwise to 0x8000. out_ovf still reports the event.
- Not defined: wrap-around, i.e. the raw s[15:0].
- With SCALE=1 the macro has no effect.

Test Plan:
- SCALE=1 basic case:
  - Stimulus: A=(0x1000,0x0200), B=(0x0800,0xFF00), idx=5.
  - Required response 2 cycles later: sum=(0x0C00,0x0080), dif=(0x0400,0x0180), out_idx=5, out_ovf=0.
- SCALE=0 overflow:
  - Stimulus: A.re=0x7000, B.re=0x2000.
  - Required response: sum.re=0x9000 without BFLY_SAT_EN, 0x7FFF with it. out_ovf=1 and ovf_sticky=1.
  - The same stimulus with SCALE=1 gives sum.re=0x4800 and out_ovf=0.
- SCALE=0 negative overflow:
  - Stimulus: A.re=0x8000, B.re=0x0001.
  - Required response: dif.re=0x7FFF (wrap) or 0x8000 (BFLY_SAT_EN). Then clr_ovf for one cycle drives ovf_sticky to 0.
- Backpressure:
  - Stimulus: 4 back-to-back pairs with out_ready=0.
  - Required response: the first 2 are accepted, after which in_ready=0 and the outputs stay stable.
  - When out_ready=1, all 4 results emerge in order with tags intact and one output per cycle.
- Streaming:
  - Stimulus: 64 random pairs with random out_ready and random in_valid gaps.
  - Required response: a scoreboard matches every result against a 17-bit reference model. There is no loss or duplication.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while 2 pairs are in flight.
  - Required response: out_valid drops immediately and ovf_sticky=0. After release, a new pair produces the correct result with latency 2.
